// File: rtl/ifetch_align_pkg.sv
// ifetch_align_pkg: fetch FSM states, IF/ID payload and RVC length helper shared by the fetch front end
package ifetch_align_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {START, FETCH, WAIT, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } id_state_t;
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/ifetch_align_hw_align_buf.sv
// hw_align_buf: 3-entry halfword queue; entry 0 (bits [15:0]) is the head
module hw_align_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push1,
  input  logic        push2,
  input  logic [31:0] word,
  input  logic        pop1,
  input  logic        pop2,
  output logic [1:0]  cnt,
  output logic [15:0] head,
  output logic [15:0] nxt
);
  logic [47:0] hw_q, hw_d, kept, ins_mask;
  logic [31:0] src, mask;
  logic [1:0]  pop_n, push_n, rem;
  // Pop shifts the queue down, then the pushed halfwords land right after what remains.
  always_comb begin
    pop_n    = pop2 ? 2'd2 : {1'b0, pop1};
    push_n   = push2 ? 2'd2 : {1'b0, push1};
    rem      = cnt - pop_n;
    kept     = hw_q >> {pop_n, 4'b0};
    src      = push1 ? {16'h0, word[31:16]} : word;
    mask     = push2 ? 32'hffff_ffff : push1 ? 32'h0000_ffff : 32'h0;
    ins_mask = {16'h0, mask} << {rem, 4'b0};
    hw_d     = (kept & ~ins_mask) | ({16'h0, src & mask} << {rem, 4'b0});
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hw_q <= '0;
      cnt  <= '0;
    end else begin
      hw_q <= hw_d;
      cnt  <= flush ? 2'd0 : rem + push_n;
    end
  assign head = hw_q[15:0];
  assign nxt  = hw_q[31:16];
endmodule

// File: rtl/ifetch_align.sv
// ifetch_align: word fetcher plus halfword realigner feeding whole RV32IC instructions to decode
module ifetch_align
  import ifetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction,
  output logic        id_compressed
);
  fetch_state_t state, state_d;
  id_state_t    id;
  logic [31:0]  fetch_addr, fetch_addr_d, pc, pc_d;
  logic [15:0]  head, nxt;
  logic [1:0]   cnt;
  logic         skip_low, skip_low_d, wide, hs, push, pop, unused;
  hw_align_buf u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push1 (push && skip_low),
    .push2 (push && !skip_low),
    .word  (imem_rsp_data),
    .pop1  (pop && !wide),
    .pop2  (pop && wide),
    .cnt   (cnt),
    .head  (head),
    .nxt   (nxt)
  );
  assign unused = redirect_pc[0];
  always_comb begin
    wide           = !is_rvc(head);
    id_valid       = (wide ? cnt[1] : cnt != 2'd0) && !redirect_valid;
    pop            = id_valid && id_ready;
    imem_req_valid = state == FETCH && cnt <= 2'd1;
    hs             = imem_req_valid && imem_req_ready;
    // A response landing in the redirect cycle belongs to the old stream.
    push           = state == WAIT && imem_rsp_valid && !redirect_valid;
    state_d        = state == START ? FETCH
                   : state == FETCH ? (hs ? (redirect_valid ? DRAIN : WAIT) : FETCH)
                   : imem_rsp_valid ? FETCH
                   : state == WAIT && redirect_valid ? DRAIN : state;
    fetch_addr_d   = redirect_valid ? {redirect_pc[31:2], 2'b00} : hs ? fetch_addr + 32'd4 : fetch_addr;
    pc_d           = redirect_valid ? {redirect_pc[31:1], 1'b0} : pop ? pc + (wide ? 32'd4 : 32'd2) : pc;
    skip_low_d     = redirect_valid ? redirect_pc[1] : push ? 1'b0 : skip_low;
    id.pc          = pc;
    id.instruction = !id_valid ? 32'h0 : wide ? {nxt, head} : {16'h0, head};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= START;
      fetch_addr <= RESET_PC;
      pc         <= RESET_PC;
      skip_low   <= 1'b0;
    end else begin
      state      <= state_d;
      fetch_addr <= fetch_addr_d;
      pc         <= pc_d;
      skip_low   <= skip_low_d;
    end
  assign imem_req_addr  = fetch_addr;
  assign id_pc          = id.pc;
  assign id_instruction = id.instruction;
  assign id_compressed  = id_valid && !wide;
endmodule

// File: doc/ifetch_align.md
# ifetch_align

Instruction-fetch front end for the RV32IC pipeline: issues word-aligned requests to instruction memory, realigns the returned halfword stream into whole 16- or 32-bit instructions, and hands them with their PC to the decode stage over a valid/ready handshake. It is the producing end of the IF/ID interface: the decoder consumes exactly what this block emits. Branch and jump redirects from EX flush it.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 must be 0.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word address of the request; bits [1:0] always 0.
- imem_rsp_valid  in  1  read data valid; exactly one response per accepted request.
- imem_rsp_data  in  32  little-endian word; the low halfword sits at the lower address.
- redirect_valid  in  1  control-flow redirect from EX.
- redirect_pc  in  32  redirect target; bit 0 ignored.
- id_valid  out  1  an instruction is presented to decode.
- id_ready  in  1  decode accepts the instruction.
- id_pc  out  32  PC of the presented instruction.
- id_instruction  out  32  raw instruction; for a 16-bit instruction, bits [31:16] are 0.
- id_compressed  out  1  1 when the presented instruction is 16-bit.

## Operation
- Halfword buffer: 3 entries × 16 bits, with count hw_cnt from 0 to 3. The head entry is the halfword at id_pc.
- Instruction length: if head[1:0] == 2'b11 the instruction is 32-bit and needs hw_cnt ≥ 2; otherwise it is 16-bit and needs hw_cnt ≥ 1.
- id_valid = length condition met AND NOT redirect_valid.
- The id_* outputs are driven combinationally from buffer state. When id_valid = 0, id_instruction and id_compressed are 0.
- Pop on id_valid && id_ready: remove 1 or 2 halfwords; id_pc += 2 or 4 (mod 2^32).
- FSM states:
  - START: reset state; go to FETCH on the next cycle.
  - FETCH: imem_req_valid = (hw_cnt ≤ 1). On request handshake: go to WAIT and advance fetch_addr by 4.
  - WAIT: imem_req_valid = 0. On imem_rsp_valid: push the word into the buffer and go to FETCH.
  - DRAIN: imem_req_valid = 0. On imem_rsp_valid: discard the word and go to FETCH.
- Push: normally 2 halfwords, low halfword first. If skip_low = 1, push only the high halfword and clear skip_low.
- A push and a pop in the same cycle both take effect: hw_cnt_next = hw_cnt − pop + push. Overflow cannot occur because a request is only issued when hw_cnt ≤ 1.
- Redirect has priority over every other event:
  - hw_cnt ← 0
  - id_pc ← {redirect_pc[31:1], 0}
  - fetch_addr ← {redirect_pc[31:2], 00}
  - skip_low ← redirect_pc[1]
- Next state on redirect:
  - From WAIT without imem_rsp_valid: go to DRAIN.
  - From WAIT with imem_rsp_valid in the same cycle: discard the response and go to FETCH.
  - From FETCH with a request handshake in the same cycle: go to DRAIN.
  - From FETCH with no handshake: stay in FETCH.
  - From DRAIN without a response: stay in DRAIN, with the target updated.
  - From DRAIN with a response: go to FETCH.
  - From START: go to FETCH.
- At most one request is outstanding at any time.

## Timing
- Reset values: state START, hw_cnt 0, skip_low 0, id_pc = RESET_PC, fetch_addr = RESET_PC.
- Outputs while in reset: imem_req_valid 0, imem_req_addr = RESET_PC, id_valid 0, id_instruction 0, id_compressed 0.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight response arriving after reset is released is ignored, because START does not push.
- Startup: reset released before edge E0. START→FETCH at E0; imem_req_valid = 1 in the cycle after E0.
- Latency: with imem_req_ready = 1 and the response one cycle after acceptance, id_valid is high in the cycle after the response edge, so fetch-to-decode latency is 2 cycles.
- The response arrives at least 1 cycle after request acceptance; same-cycle responses are illegal.
- Throughput: sustained 1 request per 2 cycles, i.e. 32 bits per 2 cycles.
- imem_req_valid, once high, stays high and imem_req_addr stays stable until imem_req_ready, unless a redirect occurs.
- redirect_valid is a single-cycle pulse. In that cycle id_valid is 0 and no pop occurs.

## Structure
- The shared pipeline package holds:
  - fetch_state_t enum {START, FETCH, WAIT, DRAIN};
  - function is_rvc(input [15:0] hw), which returns hw[1:0] != 2'b11;
  - the ID_STATE pc/instruction fields, which this block's id_pc and id_instruction fill.
- Sub-module hw_align_buf: the 3-entry halfword buffer. It takes push-1/push-2 and pop-1/pop-2 inputs plus a flush input, and outputs hw_cnt and the head/next halfwords.
- The FSM, PC, and fetch_addr logic live in ifetch_align.

## Test plan
- Straight-line 32-bit code: RESET_PC = 0; memory returns 0x00000013 (nop) at 0x0, 0x4, 0x8. With id_ready = 1, decode sees id_pc 0x0, 0x4, 0x8, each with id_compressed 0 and id_instruction 0x00000013.
- Mixed RVC: word at 0x0 = 0x00130001 (c.nop at 0x0, then the low half of a 32-bit instruction). Decode sees pc 0x0 with instr 0x00000001 and compressed 1. Next it sees pc 0x2 with a 32-bit instruction spanning words 0x0 and 0x4: low half 0x0013, high half from word 0x4[15:0].
- Mid-word redirect: redirect_pc = 0x102 while in FETCH. The next request goes to 0x100, the low halfword is discarded, and the first id_pc is 0x102.
- Redirect in WAIT: request to 0x8 is accepted, then redirect to 0x40 arrives before the response. The response for 0x8 is dropped (DRAIN), the next request goes to 0x40, and no instruction from 0x8 reaches decode.
- Backpressure: hold id_ready = 0 for 10 cycles. hw_cnt stays ≤ 3, no request is issued while hw_cnt ≥ 2, and id_pc and id_instruction stay stable.
- Asynchronous reset mid-WAIT: all outputs reach reset values without a clock edge. After release, the first request goes to RESET_PC.
